sram_responder: RTL and testbench
=================================

# sram_responder

Memory-side responder for the core's instruction/data SRAM port (CS/OE/WEB/A/DI/DO). It is instantiated once for IM and once for DM in the SoC top. It holds a word array with byte-write enables and returns read data one clock after the address. A streaming loader port fills the array before the core runs.

## Interface
Parameters:
- ADDR_W, 14, word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, word width; fixed at 32, and four byte lanes are assumed.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- CS  in  1  chip select; port is idle when 0.
- OE  in  1  output enable; DO updates only when 1.
- WEB  in  4  per-byte write enable, active low; WEB[i]=0 writes byte i (bits 8i+7:8i).
- A  in  ADDR_W  word address.
- DI  in  32  write data.
- DO  out  32  registered read data.
- ld_mode  in  1  1 = loader owns the array; the core port is ignored.
- ld_start  in  1  one-cycle pulse that loads the write pointer from ld_base.
- ld_base  in  ADDR_W  loader start address.
- ld_valid  in  1  loader beat valid.
- ld_data  in  32  loader beat data.
- ld_ready  out  1  loader can accept a beat.
- rd_cnt  out  32  read-access counter.
- wr_cnt  out  32  write-access counter.

## Operation
- Two-state FSM:
  - SERVE (reset state): core port active.
  - LOAD: loader active.
- Transitions:
  - SERVE→LOAD on an edge with ld_mode=1.
  - LOAD→SERVE on an edge with ld_mode=0.
- SERVE, CS=1:
  - Each byte lane with WEB[i]=0 is written from DI at A.
  - If OE=1, DO takes the word at A.
  - If some lanes are also written in the same cycle, DO returns the merged new word (write-first).
- SERVE, CS=0 or OE=0:
  - DO holds its value.
  - Writes still occur when CS=1 and OE=0.
- LOAD:
  - CS, OE, WEB, A and DI are ignored; no core writes; DO holds.
  - ld_ready = (state==LOAD), registered.
- Beat acceptance:
  - A beat is accepted when ld_valid & ld_ready.
  - An accepted beat writes all four bytes of ld_data at the pointer; the pointer then increments.
  - Wrap-around: pointer 2**ADDR_W−1 → 0.
- ld_start:
  - Sets the pointer to ld_base.
  - If a beat is accepted in the same cycle, it writes at ld_base and the pointer becomes ld_base+1.
- ld_start outside LOAD is ignored.
- Array contents are never cleared by rst. Reset during a load keeps the words already written.

## Timing
- Read latency: 1 cycle. A sampled at edge N; DO valid after edge N, held until the next enabled read.
- Writes become visible to a read at the same address in the same cycle (write-first) and in all later cycles.
- ld_ready:
  - Rises one edge after ld_mode=1 is sampled.
  - Falls on the edge where ld_mode=0 is sampled.
- The loader sustains 1 beat per cycle.
- Reset values (asynchronous): DO=0, ld_ready=0, state=SERVE, pointer=0, rd_cnt=0, wr_cnt=0.

## Configuration
- Macro: SRAM_ACCESS_CNT_EN.
- Defined:
  - rd_cnt increments on each SERVE cycle with CS=1, OE=1, WEB=4'b1111.
  - wr_cnt increments on each SERVE cycle with CS=1 and WEB≠4'b1111.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Loader beats are not counted.
- Undefined: rd_cnt and wr_cnt are tied to 0 and no counter flops exist. Ports are present in both builds.

## Structure
- Shared package mem_pkg:
  - MEM_ADDR_W=14, MEM_DATA_W=32.
  - WEB_NONE=4'b1111.
  - typedef enum logic {SERVE, LOAD} sram_state_e.
- One sub-module, sram_array: the word array with a 4-bit active-high byte-enable write port and a combinational read. sram_responder owns the FSM, pointer, DO register, write-first merge and counters.

## Test plan
- Reset: assert rst mid-cycle → DO=0, ld_ready=0, counters=0 immediately, without waiting for a clock edge.
- Word write, then read:
  - Write A=5, DI=32'hDEADBEEF, WEB=4'b0000 → DO unchanged.
  - Next cycle, read A=5 with OE=1, WEB=4'hF → DO=32'hDEADBEEF after one edge.
- Byte write with merge:
  - A=5 holds 32'hDEADBEEF; write WEB=4'b1101, DI=32'h0000_5500, OE=1 → DO=32'hDEAD55EF on the same edge.
  - A later read of A=5 → 32'hDEAD55EF.
- Loader burst with wrap:
  - ld_mode=1; ld_start with ld_base=16382; three valid beats 1, 2, 3.
  - Expected: words 16382=1, 16383=2, 0=3.
  - A core write during LOAD is ignored.
- Hold behaviour: read A=0, then drop OE with A=7 → DO keeps the A=0 value; CS=0 → DO keeps its value.
- Counters, with SRAM_ACCESS_CNT_EN:
  - 3 reads, 2 writes, 4 loader beats → rd_cnt=3, wr_cnt=2.
  - Without the macro, both read 0.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg
// Shared SRAM sizing, write-enable encoding, responder states, byte-merge helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 32;
  localparam logic [3:0] WEB_NONE = 4'b1111;

  typedef enum logic {
    SERVE = 1'b0,
    LOAD  = 1'b1
  } sram_state_e;

  // Lanes with be[i]=1 take new_w, the rest keep old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_array.sv
// ============================================================================
// sram_array
// Word array with active-high byte-enable write port and combinational read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_array #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents survive reset, so the array has no reset term.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sram_responder.sv
// ============================================================================
// sram_responder
// SRAM-port responder with 1-cycle read, write-first merge and streaming loader.
// Optional access counters enabled by macro SRAM_ACCESS_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              OE,
  input  logic [3:0]        WEB,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic              ld_mode,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  sram_state_e       r_state;
  logic              r_ld_ready;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_do;

  logic              w_serve;
  logic              w_load;
  logic              w_beat;
  logic [ADDR_W-1:0] w_ptr_base;
  logic [3:0]        w_core_be;
  logic [3:0]        w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_rd_merged;

  assign w_serve    = (r_state == SERVE);
  assign w_load     = (r_state == LOAD);
  assign w_beat     = ld_valid & r_ld_ready;
  // ld_start redirects the pointer before a same-cycle beat uses it.
  assign w_ptr_base = (w_load & ld_start) ? ld_base : r_ptr;
  assign w_core_be  = (w_serve & CS) ? ~WEB : 4'b0000;

  assign w_we    = w_beat ? 4'b1111 : w_core_be;
  assign w_waddr = w_beat ? w_ptr_base : A;
  assign w_wdata = w_beat ? ld_data : DI;

  sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (A),
    .o_rdata (w_rdata)
  );

  assign w_rd_merged = merge_bytes(w_rdata, DI, w_core_be);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SERVE;
      r_ld_ready <= 1'b0;
      r_ptr      <= '0;
      r_do       <= '0;
    end else begin
      r_state    <= ld_mode ? LOAD : SERVE;
      r_ld_ready <= ld_mode;
      if (w_load) r_ptr <= w_ptr_base + {{(ADDR_W-1){1'b0}}, w_beat};
      if (w_serve & CS & OE) r_do <= w_rd_merged;
    end
  end

  assign DO       = r_do;
  assign ld_ready = r_ld_ready;

`ifdef SRAM_ACCESS_CNT_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_serve & CS & OE & (WEB == WEB_NONE) & (r_rd_cnt != 32'hFFFF_FFFF))
        r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_serve & CS & (WEB != WEB_NONE) & (r_wr_cnt != 32'hFFFF_FFFF))
        r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`else
  assign rd_cnt = 32'd0;
  assign wr_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// ============================================================================
// tb_sram_responder
// Directed self-checking bench for sram_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_responder;

  logic        clk;
  logic        rst;
  logic        CS;
  logic        OE;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic        ld_mode;
  logic        ld_start;
  logic [13:0] ld_base;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  sram_responder #(
    .ADDR_W (14),
    .DATA_W (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .CS       (CS),
    .OE       (OE),
    .WEB      (WEB),
    .A        (A),
    .DI       (DI),
    .DO       (DO),
    .ld_mode  (ld_mode),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic core(input logic cs, input logic oe, input logic [3:0] web,
                      input logic [13:0] a, input logic [31:0] di);
    CS = cs; OE = oe; WEB = web; A = a; DI = di;
  endtask

  logic [31:0] exp_rd;
  logic [31:0] exp_wr;

  initial begin
`ifdef SRAM_ACCESS_CNT_EN
    exp_rd = 32'd6;
    exp_wr = 32'd3;
`else
    exp_rd = 32'd0;
    exp_wr = 32'd0;
`endif
    rst = 1'b1;
    core(1'b0, 1'b0, 4'hF, 14'd0, 32'd0);
    ld_mode = 1'b0; ld_start = 1'b0; ld_base = 14'd0; ld_valid = 1'b0; ld_data = 32'd0;
    tick(); tick();
    rst = 1'b0;
    check("reset_do", DO, 32'h0);
    check("reset_ld_ready", {31'd0, ld_ready}, 32'd0);

    // Full-word write, DO must not move
    core(1'b1, 1'b0, 4'b0000, 14'd5, 32'hDEADBEEF);
    tick();
    check("write_do_unchanged", DO, 32'h0);

    core(1'b1, 1'b1, 4'hF, 14'd5, 32'h0);
    tick();
    check("read_a5", DO, 32'hDEADBEEF);

    // Byte write with same-cycle read returns merged word
    core(1'b1, 1'b1, 4'b1101, 14'd5, 32'h0000_5500);
    tick();
    check("merge_same_edge", DO, 32'hDEAD55EF);

    core(1'b1, 1'b1, 4'hF, 14'd5, 32'h0);
    tick();
    check("read_after_merge", DO, 32'hDEAD55EF);

    core(1'b1, 1'b0, 4'b0000, 14'd9, 32'h1234_5678);
    tick();
    check("ld_ready_before_load", {31'd0, ld_ready}, 32'd0);

    // Enter LOAD
    core(1'b0, 1'b0, 4'hF, 14'd0, 32'h0);
    ld_mode = 1'b1;
    tick();
    check("ld_ready_rise", {31'd0, ld_ready}, 32'd1);

    // Beat 1 with ld_start at 16382, plus an ignored core write
    core(1'b1, 1'b1, 4'b0000, 14'd9, 32'hFFFF_FFFF);
    ld_start = 1'b1; ld_base = 14'd16382; ld_valid = 1'b1; ld_data = 32'd1;
    tick();
    check("load_do_hold", DO, 32'hDEAD55EF);
    ld_start = 1'b0; ld_data = 32'd2;
    tick();
    ld_data = 32'd3;
    tick();
    ld_data = 32'd4;
    tick();
    ld_valid = 1'b0;
    core(1'b0, 1'b0, 4'hF, 14'd0, 32'h0);
    ld_mode = 1'b0;
    tick();
    check("ld_ready_fall", {31'd0, ld_ready}, 32'd0);

    core(1'b1, 1'b1, 4'hF, 14'd16382, 32'h0);
    tick();
    check("load_word_16382", DO, 32'd1);
    core(1'b1, 1'b1, 4'hF, 14'd16383, 32'h0);
    tick();
    check("load_word_16383", DO, 32'd2);
    core(1'b1, 1'b1, 4'hF, 14'd9, 32'h0);
    tick();
    check("core_write_in_load_ignored", DO, 32'h1234_5678);
    core(1'b1, 1'b1, 4'hF, 14'd0, 32'h0);
    tick();
    check("load_wrap_word_0", DO, 32'd3);

    // Hold behaviour
    core(1'b1, 1'b0, 4'hF, 14'd7, 32'h0);
    tick();
    check("hold_oe_low", DO, 32'd3);
    core(1'b0, 1'b1, 4'hF, 14'd16383, 32'h0);
    tick();
    check("hold_cs_low", DO, 32'd3);

    check("rd_cnt", rd_cnt, exp_rd);
    check("wr_cnt", wr_cnt, exp_wr);

    // Asynchronous reset mid-cycle
    core(1'b0, 1'b0, 4'hF, 14'd0, 32'h0);
    ld_mode = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_do", DO, 32'h0);
    check("async_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("async_rst_rd_cnt", rd_cnt, 32'd0);
    check("async_rst_wr_cnt", wr_cnt, 32'd0);
    ld_mode = 1'b0;
    rst = 1'b0;
    tick();

    // Array contents survive reset; loader beat 4 went to word 1
    core(1'b1, 1'b1, 4'hF, 14'd5, 32'h0);
    tick();
    check("retain_after_rst", DO, 32'hDEAD55EF);
    core(1'b1, 1'b1, 4'hF, 14'd1, 32'h0);
    tick();
    check("load_word_1", DO, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
